gba_ds_fifo: RTL and testbench

GBA_DS_FIFO -- requirements
Module: gba_ds_fifo

---
 rtl/gba_ds_fifo.sv | 104 ++++++++++
 tb/tb_gba_ds_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gba_ds_fifo.sv
// Direct-sound sample FIFO for one GBA sound channel: 8 x 32-bit words, halfword
// assembly through a low-half staging register, registered head-word read-ahead.
module gba_ds_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        gba_clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        wr_word,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic        FIFO_re,
  input  logic        FIFO_clr,
  output logic [3:0]  FIFO_size,
  output logic [31:0] FIFO_val,
  output logic        overflow
);

  logic [31:0] mem [DEPTH];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;
  logic [15:0] stage_lo;
  logic [31:0] head_p1;
  logic        ovf_p1;

  logic        push_p0;
  logic        stage_ld_p0;
  logic        pop_p0;
  logic        full_p0;
  logic        empty_p0;
  logic        push_ok_p0;
  logic        drop_p0;
  logic [31:0] word_p0;
  logic [31:0] head_p0;
  logic [2:0]  wr_ptr_p0;
  logic [2:0]  rd_ptr_p0;
  logic [3:0]  count_p0;

  // Stage p0: decode the bus write, resolve push/pop and precompute the next head.
  always_comb begin
    full_p0     = (count == 4'(DEPTH));
    empty_p0    = (count == 4'd0);
    push_p0     = wr_en & (wr_word | wr_hi);
    stage_ld_p0 = wr_en & ~wr_word & ~wr_hi;
    pop_p0      = FIFO_re & ~empty_p0;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    push_ok_p0  = push_p0 & (~full_p0 | pop_p0);
    drop_p0     = push_p0 & full_p0 & ~pop_p0;
    word_p0     = wr_word ? wr_data : {wr_data[15:0], stage_lo};
    wr_ptr_p0   = wr_ptr + {2'b00, push_ok_p0};
    rd_ptr_p0   = rd_ptr + {2'b00, pop_p0};
    count_p0    = count + {3'b000, push_ok_p0} - {3'b000, pop_p0};
    // The new head is the word being written only when it becomes the sole entry.
    if (count_p0 == 4'd0) begin
      head_p0 = 32'h0;
    end else if (push_ok_p0 && (wr_ptr == rd_ptr_p0)) begin
      head_p0 = word_p0;
    end else begin
      head_p0 = mem[rd_ptr_p0];
    end
  end

  // Stage p1: storage, pointers and registered outputs.
  always_ff @(posedge gba_clk) begin
    if (reset_n && !FIFO_clr && push_ok_p0) begin
      mem[wr_ptr] <= word_p0;
    end
  end

  always_ff @(posedge gba_clk) begin
    if (!reset_n) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      stage_lo <= 16'h0;
      head_p1  <= 32'h0;
      ovf_p1   <= 1'b0;
    end else if (FIFO_clr) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      stage_lo <= 16'h0;
      head_p1  <= 32'h0;
      ovf_p1   <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_p0;
      rd_ptr  <= rd_ptr_p0;
      count   <= count_p0;
      head_p1 <= head_p0;
      ovf_p1  <= drop_p0;
      if (stage_ld_p0) begin
        stage_lo <= wr_data[15:0];
      end else if (wr_en && !wr_word && wr_hi) begin
        stage_lo <= 16'h0;
      end
    end
  end

  assign FIFO_size = count;
  assign FIFO_val  = head_p1;
  assign overflow  = ovf_p1;

endmodule

// File: tb/tb_gba_ds_fifo.sv
// Self-checking bench for gba_ds_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_gba_ds_fifo;

  logic        gba_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_word = 1'b0;
  logic        wr_hi = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        FIFO_re = 1'b0;
  logic        FIFO_clr = 1'b0;
  logic [3:0]  FIFO_size;
  logic [31:0] FIFO_val;
  logic        overflow;

  int total = 0;
  int bad = 0;

  logic [31:0] mq[$];
  logic [15:0] m_stage = 16'h0;
  logic        m_ovf = 1'b0;

  gba_ds_fifo #(.DEPTH(8)) dut (
    .gba_clk  (gba_clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_word  (wr_word),
    .wr_hi    (wr_hi),
    .wr_data  (wr_data),
    .FIFO_re  (FIFO_re),
    .FIFO_clr (FIFO_clr),
    .FIFO_size(FIFO_size),
    .FIFO_val (FIFO_val),
    .overflow (overflow)
  );

  always #5 gba_clk = ~gba_clk;

  // Drive one cycle of inputs, clock it, and advance the reference model.
  task automatic cyc(input logic rn, input logic en, input logic wd, input logic hi,
                     input logic [31:0] d, input logic re, input logic clr);
    logic        pop;
    logic        push;
    logic [31:0] w;
    reset_n = rn; wr_en = en; wr_word = wd; wr_hi = hi; wr_data = d;
    FIFO_re = re; FIFO_clr = clr;
    @(posedge gba_clk);
    #1;
    if (!rn || clr) begin
      mq.delete();
      m_stage = 16'h0;
      m_ovf = 1'b0;
    end else begin
      pop  = re && (mq.size() > 0);
      push = en && (wd || hi);
      w    = wd ? d : {d[15:0], m_stage};
      m_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < 8) mq.push_back(w);
        else m_ovf = 1'b1;
      end
      if (en && !wd && !hi) m_stage = d[15:0];
      else if (en && !wd && hi) m_stage = 16'h0;
    end
    reset_n = 1'b1; wr_en = 1'b0; wr_word = 1'b0; wr_hi = 1'b0;
    FIFO_re = 1'b0; FIFO_clr = 1'b0;
  endtask

  task automatic push_w(input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd0) begin bad++; $display("FAIL reset_size got=%0d want=0", FIFO_size); end
    total++; if (FIFO_val !== 32'h0) begin bad++; $display("FAIL reset_val got=%h want=0", FIFO_val); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_word_push();
    push_w(32'h1111_1111);
    push_w(32'h2222_2222);
    total++; if (FIFO_size !== 4'd2) begin bad++; $display("FAIL word_size got=%0d want=2", FIFO_size); end
    total++; if (FIFO_val !== 32'h1111_1111) begin bad++; $display("FAIL word_head got=%h want=11111111", FIFO_val); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd1) begin bad++; $display("FAIL word_pop_size got=%0d want=1", FIFO_size); end
    total++; if (FIFO_val !== 32'h2222_2222) begin bad++; $display("FAIL word_pop_head got=%h want=22222222", FIFO_val); end
  endtask

  task automatic test_halfword();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h5555_BEEF, 1'b0, 1'b0);
    total++; if (FIFO_size !== 4'd0) begin bad++; $display("FAIL half_lo_nopush got=%0d want=0", FIFO_size); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h7777_DEAD, 1'b0, 1'b0);
    total++; if (FIFO_size !== 4'd1) begin bad++; $display("FAIL half_size got=%0d want=1", FIFO_size); end
    total++; if (FIFO_val !== 32'hDEAD_BEEF) begin bad++; $display("FAIL half_word got=%h want=deadbeef", FIFO_val); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (FIFO_val !== 32'h1234_0000) begin bad++; $display("FAIL half_hi_only got=%h want=12340000", FIFO_val); end
  endtask

  task automatic test_overflow();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push_w(32'(i));
    push_w(32'h99);
    total++; if (FIFO_size !== 4'd8) begin bad++; $display("FAIL ovf_size got=%0d want=8", FIFO_size); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", overflow); end
    idle();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b want=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      total++; if (FIFO_val !== 32'(i)) begin bad++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, FIFO_val, 32'(i)); end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    total++; if (FIFO_size !== 4'd0 || FIFO_val !== 32'h0) begin bad++; $display("FAIL ovf_drained size=%0d val=%h want 0/0", FIFO_size, FIFO_val); end
    for (int i = 0; i < 3; i++) begin push_w(32'hF0 + 32'(i)); cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0); end
    for (int i = 0; i < 8; i++) push_w(32'hA0 + 32'(i));
    total++; if (FIFO_size !== 4'd8) begin bad++; $display("FAIL wrap_size got=%0d want=8", FIFO_size); end
    for (int i = 0; i < 8; i++) begin
      total++; if (FIFO_val !== 32'hA0 + 32'(i)) begin bad++; $display("FAIL wrap_order[%0d] got=%h want=%h", i, FIFO_val, 32'hA0 + 32'(i)); end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_simultaneous();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) push_w(32'h100 + 32'(i));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h1FF, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd8) begin bad++; $display("FAIL sim_full_size got=%0d want=8", FIFO_size); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_full_ovf got=%b want=0", overflow); end
    total++; if (FIFO_val !== 32'h101) begin bad++; $display("FAIL sim_full_head got=%h want=101", FIFO_val); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd1) begin bad++; $display("FAIL sim_empty_size got=%0d want=1", FIFO_size); end
    total++; if (FIFO_val !== 32'hCAFE_F00D) begin bad++; $display("FAIL sim_empty_head got=%h want=cafef00d", FIFO_val); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd0 || FIFO_val !== 32'h0 || overflow !== 1'b0) begin
      bad++; $display("FAIL sim_pop_empty size=%0d val=%h ovf=%b want 0/0/0", FIFO_size, FIFO_val, overflow); end
  endtask

  task automatic test_clear_priority();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push_w(32'h200 + 32'(i));
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5555, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 1'b1);
    total++; if (FIFO_size !== 4'd0) begin bad++; $display("FAIL clr_size got=%0d want=0", FIFO_size); end
    total++; if (FIFO_val !== 32'h0) begin bad++; $display("FAIL clr_val got=%h want=0", FIFO_val); end
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_AAAA, 1'b0, 1'b0);
    total++; if (FIFO_val !== 32'hAAAA_0000) begin bad++; $display("FAIL clr_stage got=%h want=aaaa0000", FIFO_val); end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) push_w(32'h300 + 32'(i));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h4444_4444, 1'b1, 1'b0);
    total++; if (FIFO_size !== 4'd0 || FIFO_val !== 32'h0 || overflow !== 1'b0) begin
      bad++; $display("FAIL rst_mid size=%0d val=%h ovf=%b want 0/0/0", FIFO_size, FIFO_val, overflow); end
    push_w(32'h5A5A_5A5A);
    total++; if (FIFO_size !== 4'd1) begin bad++; $display("FAIL rst_first_push got=%0d want=1", FIFO_size); end
    total++; if (FIFO_val !== 32'h5A5A_5A5A) begin bad++; $display("FAIL rst_first_val got=%h want=5a5a5a5a", FIFO_val); end
  endtask

  task automatic test_random();
    logic [31:0] exp_val;
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 99) < 45),
          ($urandom_range(0, 99) < 3));
      exp_val = (mq.size() > 0) ? mq[0] : 32'h0;
      total++; if (FIFO_size !== 4'(mq.size())) begin bad++; $display("FAIL rnd_size[%0d] got=%0d want=%0d", n, FIFO_size, mq.size()); end
      total++; if (FIFO_val !== exp_val) begin bad++; $display("FAIL rnd_val[%0d] got=%h want=%h", n, FIFO_val, exp_val); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_ovf[%0d] got=%b want=%b", n, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_word_push();
    test_halfword();
    test_overflow();
    test_simultaneous();
    test_clear_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
